// File: rtl/sfifo_sync.sv
// Single-clock first-word-fall-through FIFO with level, almost-full and sticky
// overflow/underflow status between the servo command stream and its reader.
module sfifo_sync #(
    parameter int unsigned DW       = 16,
    parameter int unsigned AW       = 6,
    parameter int unsigned AFULL_TH = 56
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          wr_i,
    input  logic [DW-1:0] din_i,
    output logic          full_o,
    output logic          afull_o,
    input  logic          rd_i,
    output logic          empty_o,
    output logic [DW-1:0] dout_o,
    output logic [AW:0]   level_o,
    input  logic          clr_err_i,
    output logic          ovf_o,
    output logic          udf_o
);

    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned LW    = AW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          rd_acc;
    logic          wr_acc;
    logic [LW-1:0] level_nxt;

    // A write at full is still accepted when a pop frees the head slot in the same cycle.
    always_comb begin
        rd_acc    = rd_i & ~empty_o;
        wr_acc    = wr_i & (~full_o | rd_acc);
        level_nxt = level_o;
        if (wr_acc && !rd_acc) begin
            level_nxt = level_o + LW'(1);
        end else if (!wr_acc && rd_acc) begin
            level_nxt = level_o - LW'(1);
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk_i) begin
        if (wr_acc) begin
            mem[wr_ptr] <= din_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_o <= '0;
            empty_o <= 1'b1;
            full_o  <= 1'b0;
            afull_o <= 1'b0;
            ovf_o   <= 1'b0;
            udf_o   <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level_o <= level_nxt;
            empty_o <= (level_nxt == LW'(0));
            full_o  <= (level_nxt == LW'(DEPTH));
            afull_o <= (level_nxt >= LW'(AFULL_TH));
            // A fresh error outranks a clear in the same cycle.
            if (wr_i && !wr_acc) begin
                ovf_o <= 1'b1;
            end else if (clr_err_i) begin
                ovf_o <= 1'b0;
            end
            if (rd_i && empty_o) begin
                udf_o <= 1'b1;
            end else if (clr_err_i) begin
                udf_o <= 1'b0;
            end
        end
    end

    assign dout_o = empty_o ? '0 : mem[rd_ptr];

endmodule

// File: tb/tb_sfifo_sync.sv
// Randomised bench for sfifo_sync against a queue-based FIFO reference model.
module tb_sfifo_sync;

    logic        clk_i;
    logic        rst_ni;
    logic        wr_i;
    logic [15:0] din_i;
    logic        full_o;
    logic        afull_o;
    logic        rd_i;
    logic        empty_o;
    logic [15:0] dout_o;
    logic [6:0]  level_o;
    logic        clr_err_i;
    logic        ovf_o;
    logic        udf_o;

    int total = 0;
    int bad   = 0;

    logic [15:0] mq[$];
    logic        m_ovf = 1'b0;
    logic        m_udf = 1'b0;
    logic        seen_dead = 1'b0;

    sfifo_sync #(.DW(16), .AW(6), .AFULL_TH(56)) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .wr_i     (wr_i),
        .din_i    (din_i),
        .full_o   (full_o),
        .afull_o  (afull_o),
        .rd_i     (rd_i),
        .empty_o  (empty_o),
        .dout_o   (dout_o),
        .level_o  (level_o),
        .clr_err_i(clr_err_i),
        .ovf_o    (ovf_o),
        .udf_o    (udf_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_state(input string tag);
        int n;
        n = mq.size();
        check({tag, "_level"}, 32'(level_o), 32'(n));
        check({tag, "_empty"}, 32'(empty_o), 32'(n == 0));
        check({tag, "_full"},  32'(full_o),  32'(n == 64));
        check({tag, "_afull"}, 32'(afull_o), 32'(n >= 56));
        check({tag, "_dout"},  32'(dout_o),  (n > 0) ? 32'(mq[0]) : 32'd0);
        check({tag, "_ovf"},   32'(ovf_o),   32'(m_ovf));
        check({tag, "_udf"},   32'(udf_o),   32'(m_udf));
        if (dout_o == 16'hDEAD) seen_dead = 1'b1;
    endtask

    // One clock: drive at negedge, apply FIFO rules to the model, check at next negedge.
    task automatic step(input string tag, input logic wr, input logic [15:0] d,
                        input logic rd, input logic clr);
        logic ra;
        logic wa;
        wr_i      = wr;
        din_i     = d;
        rd_i      = rd;
        clr_err_i = clr;
        ra = rd && (mq.size() > 0);
        wa = wr && ((mq.size() < 64) || ra);
        @(posedge clk_i);
        if (ra) void'(mq.pop_front());
        if (wa) mq.push_back(d);
        if (wr && !wa)      m_ovf = 1'b1;
        else if (clr)       m_ovf = 1'b0;
        if (rd && !ra)      m_udf = 1'b1;
        else if (clr)       m_udf = 1'b0;
        @(negedge clk_i);
        wr_i      = 1'b0;
        rd_i      = 1'b0;
        clr_err_i = 1'b0;
        chk_state(tag);
    endtask

    initial begin
        rst_ni    = 1'b0;
        wr_i      = 1'b0;
        rd_i      = 1'b0;
        din_i     = '0;
        clr_err_i = 1'b0;
        #12;
        chk_state("rst_init");
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Asynchronous reset in the middle of a burst at level 10.
        for (int i = 0; i < 10; i++) step("burst", 1'b1, 16'(16'h0100 + i), 1'b0, 1'b0);
        check("burst_lvl10", 32'(level_o), 32'd10);
        wr_i  = 1'b1;
        din_i = 16'h0A0A;
        #2;
        rst_ni = 1'b0;
        #1;
        check("arst_empty", 32'(empty_o), 32'd1);
        check("arst_level", 32'(level_o), 32'd0);
        check("arst_dout",  32'(dout_o),  32'd0);
        check("arst_flags", {30'd0, ovf_o, udf_o}, 32'd0);
        check("arst_full",  {30'd0, full_o, afull_o}, 32'd0);
        mq.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        wr_i  = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk_state("post_rst");

        // Fill 1..64 with the almost-full and full edges checked explicitly.
        for (int i = 1; i <= 64; i++) begin
            step("fill", 1'b1, 16'(i), 1'b0, 1'b0);
            if (i == 55) check("afull_55", 32'(afull_o), 32'd0);
            if (i == 56) check("afull_56", 32'(afull_o), 32'd1);
            if (i == 63) check("full_63",  32'(full_o),  32'd0);
        end
        check("full_64", 32'(full_o), 32'd1);

        // Overflow at full, then clear.
        step("ovf", 1'b1, 16'hDEAD, 1'b0, 1'b0);
        check("ovf_set", 32'(ovf_o), 32'd1);
        check("ovf_lvl", 32'(level_o), 32'd64);
        step("clr", 1'b0, 16'h0, 1'b0, 1'b1);
        check("ovf_clr", 32'(ovf_o), 32'd0);

        // Simultaneous push and pop at full.
        step("simfull", 1'b1, 16'hBEEF, 1'b1, 1'b0);
        check("simfull_lvl", 32'(level_o), 32'd64);
        check("simfull_ovf", 32'(ovf_o), 32'd0);

        // Drain: 2..64 followed by 0xBEEF as the 64th word.
        for (int i = 1; i <= 64; i++) begin
            if (i == 64) check("beef_64th", 32'(dout_o), 32'h0000BEEF);
            else         check("drain_ord", 32'(dout_o), 32'(i + 1));
            step("drain", 1'b0, 16'h0, 1'b1, 1'b0);
        end
        check("drain_empty", 32'(empty_o), 32'd1);
        check("dead_never", 32'(seen_dead), 32'd0);

        // Push and pop while empty.
        step("emptysim", 1'b1, 16'h1234, 1'b1, 1'b0);
        check("emptysim_udf",  32'(udf_o),   32'd1);
        check("emptysim_lvl",  32'(level_o), 32'd1);
        check("emptysim_dout", 32'(dout_o),  32'h00001234);
        step("clr2", 1'b0, 16'h0, 1'b0, 1'b1);

        // Random traffic with wrap-around; model compared every cycle.
        for (int i = 0; i < 200; i++) begin
            step("rand", 1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 15) == 0));
        end
        // Pin the clear-versus-new-error priority.
        while (mq.size() > 0) step("flush", 1'b0, 16'h0, 1'b1, 1'b0);
        step("udf_vs_clr", 1'b0, 16'h0, 1'b1, 1'b1);
        check("udf_wins", 32'(udf_o), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
